// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use hazard detection.
// Captures decoded operands/control for the execute stage and inserts a bubble
// on load-use hazards or branch flushes. It holds its contents on memory stalls
// and keeps a saturating count of load-use bubbles.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_Rs1,
    input  logic [4:0]      id_Rs2,
    input  logic [4:0]      id_Rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            id_RegWrite,
    input  logic            id_MemRead,
    input  logic            id_MemWrite,
    input  logic            id_MemToReg,
    input  logic            id_ALUSrc,
    input  logic [3:0]      id_ALUOp,
    input  logic            flush,
    input  logic            mem_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      Rs1,
    output logic [4:0]      Rs2,
    output logic [4:0]      Rd,
    output logic            Wb,
    output logic            ex_MemRead,
    output logic            ex_MemWrite,
    output logic            ex_MemToReg,
    output logic            ex_ALUSrc,
    output logic [3:0]      ex_ALUOp,
    output logic            pc_write_en,
    output logic            if_id_write_en,
    output logic            load_use_stall,
    output logic [CNTW-1:0] bubble_count
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // EX-side state registers
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_wb;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_mem_to_reg;
    logic            r_alu_src;
    logic [3:0]      r_alu_op;
    logic [CNTW-1:0] r_bubble_count;

    // Next-state values for the EX registers
    logic            w_load_use;
    logic            w_bubble;
    logic            w_hold;
    logic            w_cnt_inc;
    logic            w_nxt_valid;
    logic [XLEN-1:0] w_nxt_pc;
    logic [XLEN-1:0] w_nxt_rs1_data;
    logic [XLEN-1:0] w_nxt_rs2_data;
    logic [XLEN-1:0] w_nxt_imm;
    logic [4:0]      w_nxt_rs1;
    logic [4:0]      w_nxt_rs2;
    logic [4:0]      w_nxt_rd;
    logic            w_nxt_wb;
    logic            w_nxt_mem_read;
    logic            w_nxt_mem_write;
    logic            w_nxt_mem_to_reg;
    logic            w_nxt_alu_src;
    logic [3:0]      w_nxt_alu_op;

    // Load-use hazard: a load in EX whose nonzero Rd feeds an operand that ID actually reads
    always_comb begin
        w_load_use = r_valid & r_mem_read & (r_rd != 5'd0) & id_valid &
                     ((id_uses_rs1 & (id_Rs1 == r_rd)) | (id_uses_rs2 & (id_Rs2 == r_rd)));
    end

    // Edge control: flush beats a memory stall, which beats a load-use bubble
    always_comb begin
        w_bubble  = flush | w_load_use;
        w_hold    = mem_stall & ~flush;
        w_cnt_inc = w_load_use & ~flush & ~mem_stall & (r_bubble_count != CNT_MAX);
    end

    // Next EX contents: either a zeroed bubble or the qualified decode fields
    always_comb begin
        if (w_bubble) begin
            w_nxt_valid      = 1'b0;
            w_nxt_pc         = {XLEN{1'b0}};
            w_nxt_rs1_data   = {XLEN{1'b0}};
            w_nxt_rs2_data   = {XLEN{1'b0}};
            w_nxt_imm        = {XLEN{1'b0}};
            w_nxt_rs1        = 5'd0;
            w_nxt_rs2        = 5'd0;
            w_nxt_rd         = 5'd0;
            w_nxt_wb         = 1'b0;
            w_nxt_mem_read   = 1'b0;
            w_nxt_mem_write  = 1'b0;
            w_nxt_mem_to_reg = 1'b0;
            w_nxt_alu_src    = 1'b0;
            w_nxt_alu_op     = 4'd0;
        end else begin
            w_nxt_valid      = id_valid;
            w_nxt_pc         = id_pc;
            w_nxt_rs1_data   = id_rs1_data;
            w_nxt_rs2_data   = id_rs2_data;
            w_nxt_imm        = id_imm;
            w_nxt_rs1        = id_Rs1;
            w_nxt_rs2        = id_Rs2;
            w_nxt_rd         = id_Rd;
            w_nxt_wb         = id_RegWrite & id_valid;
            w_nxt_mem_read   = id_MemRead & id_valid;
            w_nxt_mem_write  = id_MemWrite & id_valid;
            w_nxt_mem_to_reg = id_MemToReg & id_valid;
            w_nxt_alu_src    = id_ALUSrc & id_valid;
            w_nxt_alu_op     = id_ALUOp & {4{id_valid}};
        end
    end

    // EX register bank: synchronous clear, hold on memory stall, else load next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_pc         <= {XLEN{1'b0}};
            r_rs1_data   <= {XLEN{1'b0}};
            r_rs2_data   <= {XLEN{1'b0}};
            r_imm        <= {XLEN{1'b0}};
            r_rs1        <= 5'd0;
            r_rs2        <= 5'd0;
            r_rd         <= 5'd0;
            r_wb         <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_op     <= 4'd0;
        end else if (!w_hold) begin
            r_valid      <= w_nxt_valid;
            r_pc         <= w_nxt_pc;
            r_rs1_data   <= w_nxt_rs1_data;
            r_rs2_data   <= w_nxt_rs2_data;
            r_imm        <= w_nxt_imm;
            r_rs1        <= w_nxt_rs1;
            r_rs2        <= w_nxt_rs2;
            r_rd         <= w_nxt_rd;
            r_wb         <= w_nxt_wb;
            r_mem_read   <= w_nxt_mem_read;
            r_mem_write  <= w_nxt_mem_write;
            r_mem_to_reg <= w_nxt_mem_to_reg;
            r_alu_src    <= w_nxt_alu_src;
            r_alu_op     <= w_nxt_alu_op;
        end else begin
            r_valid      <= r_valid;
        end
    end

    // Saturating load-use bubble counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_count <= {CNTW{1'b0}};
        end else if (w_cnt_inc) begin
            r_bubble_count <= r_bubble_count + CNT_ONE;
        end else begin
            r_bubble_count <= r_bubble_count;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_pc          = r_pc;
    assign ex_rs1_data    = r_rs1_data;
    assign ex_rs2_data    = r_rs2_data;
    assign ex_imm         = r_imm;
    assign Rs1            = r_rs1;
    assign Rs2            = r_rs2;
    assign Rd             = r_rd;
    assign Wb             = r_wb;
    assign ex_MemRead     = r_mem_read;
    assign ex_MemWrite    = r_mem_write;
    assign ex_MemToReg    = r_mem_to_reg;
    assign ex_ALUSrc      = r_alu_src;
    assign ex_ALUOp       = r_alu_op;
    assign bubble_count   = r_bubble_count;
    assign load_use_stall = w_load_use;
    assign pc_write_en    = ~(mem_stall | w_load_use);
    assign if_id_write_en = ~(mem_stall | w_load_use);

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage (CNTW=4 build so saturation is reachable).
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic reset, id_valid, id_uses_rs1, id_uses_rs2;
    logic id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc;
    logic flush, mem_stall;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0] id_Rs1, id_Rs2, id_Rd;
    logic [3:0] id_ALUOp;
    logic ex_valid, Wb, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_ALUSrc;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0] Rs1, Rs2, Rd;
    logic [3:0] ex_ALUOp;
    logic pc_write_en, if_id_write_en, load_use_stall;
    logic [CNTW-1:0] bubble_count;

    id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_Rs1(id_Rs1), .id_Rs2(id_Rs2), .id_Rd(id_Rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_MemToReg(id_MemToReg), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
        .flush(flush), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
        .Wb(Wb), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemToReg(ex_MemToReg), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, fl, ms, v, u1, u2, rw, mr, mw, mtr, als;
        logic [31:0] pc, a, b, imm;
        logic [4:0] rs1, rs2, rd;
        logic [3:0] op;
    } stim_t;

    typedef struct {
        logic v, wb, mr, mw, mtr, als;
        logic [31:0] pc, a, b, imm;
        logic [4:0] rs1, rs2, rd;
        logic [3:0] op;
        int cnt;
    } ex_t;

    ex_t exp_q[$];
    ex_t m;
    bit  m_init = 1'b0;
    int  checks = 0;
    int  errors = 0;
    int  hazards_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ex_t bubble_of(input ex_t cur);
        ex_t b;
        b = '{v:1'b0, wb:1'b0, mr:1'b0, mw:1'b0, mtr:1'b0, als:1'b0,
              pc:32'd0, a:32'd0, b:32'd0, imm:32'd0, rs1:5'd0, rs2:5'd0, rd:5'd0,
              op:4'd0, cnt:cur.cnt};
        return b;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst:1'b0, fl:1'b0, ms:1'b0, v:1'b0, u1:1'b0, u2:1'b0, rw:1'b0,
              mr:1'b0, mw:1'b0, mtr:1'b0, als:1'b0, pc:32'd0, a:32'd0, b:32'd0,
              imm:32'd0, rs1:5'd0, rs2:5'd0, rd:5'd0, op:4'd0};
        return s;
    endfunction

    function automatic stim_t instr(input logic [4:0] rs1, input logic u1,
                                    input logic [4:0] rs2, input logic u2,
                                    input logic [4:0] rd, input logic rw, input logic mr);
        stim_t s;
        s = idle();
        s.v = 1'b1; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
        s.rd = rd; s.rw = rw; s.mr = mr; s.mtr = mr;
        s.pc = $urandom; s.a = $urandom; s.b = $urandom; s.imm = $urandom;
        s.op = 4'($urandom_range(0, 15));
        return s;
    endfunction

    // Apply one cycle of stimulus, check combinational outputs, queue the expected EX state
    task automatic drive(input stim_t s);
        logic haz;
        ex_t  n;
        @(negedge clk);
        reset = s.rst; flush = s.fl; mem_stall = s.ms; id_valid = s.v;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; id_RegWrite = s.rw;
        id_MemRead = s.mr; id_MemWrite = s.mw; id_MemToReg = s.mtr; id_ALUSrc = s.als;
        id_pc = s.pc; id_rs1_data = s.a; id_rs2_data = s.b; id_imm = s.imm;
        id_Rs1 = s.rs1; id_Rs2 = s.rs2; id_Rd = s.rd; id_ALUOp = s.op;
        #1;
        haz = m_init && m.v && m.mr && (m.rd != 5'd0) && s.v &&
              ((s.u1 && s.rs1 == m.rd) || (s.u2 && s.rs2 == m.rd));
        if (m_init) begin
            chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, haz});
            chk("pc_write_en", {31'd0, pc_write_en}, {31'd0, !(s.ms || haz)});
            chk("if_id_write_en", {31'd0, if_id_write_en}, {31'd0, !(s.ms || haz)});
            if (haz) hazards_seen++;
        end
        if (s.rst) begin
            n = bubble_of(m);
            n.cnt = 0;
            m_init = 1'b1;
        end else if (s.fl) begin
            n = bubble_of(m);
        end else if (s.ms) begin
            n = m;
        end else if (haz) begin
            n = bubble_of(m);
            n.cnt = (m.cnt < CMAX) ? m.cnt + 1 : CMAX;
        end else begin
            n = '{v:s.v, wb:s.rw && s.v, mr:s.mr && s.v, mw:s.mw && s.v,
                  mtr:s.mtr && s.v, als:s.als && s.v, pc:s.pc, a:s.a, b:s.b,
                  imm:s.imm, rs1:s.rs1, rs2:s.rs2, rd:s.rd,
                  op:(s.v ? s.op : 4'd0), cnt:m.cnt};
        end
        m = n;
        if (m_init) exp_q.push_back(n);
    endtask

    // Monitor: after every rising edge compare registered outputs to the oldest expectation
    initial begin
        ex_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
                chk("Wb", {31'd0, Wb}, {31'd0, e.wb});
                chk("ex_MemRead", {31'd0, ex_MemRead}, {31'd0, e.mr});
                chk("ex_MemWrite", {31'd0, ex_MemWrite}, {31'd0, e.mw});
                chk("ex_MemToReg", {31'd0, ex_MemToReg}, {31'd0, e.mtr});
                chk("ex_ALUSrc", {31'd0, ex_ALUSrc}, {31'd0, e.als});
                chk("ex_ALUOp", {28'd0, ex_ALUOp}, {28'd0, e.op});
                chk("ex_pc", ex_pc, e.pc);
                chk("ex_rs1_data", ex_rs1_data, e.a);
                chk("ex_rs2_data", ex_rs2_data, e.b);
                chk("ex_imm", ex_imm, e.imm);
                chk("Rs1", {27'd0, Rs1}, {27'd0, e.rs1});
                chk("Rs2", {27'd0, Rs2}, {27'd0, e.rs2});
                chk("Rd", {27'd0, Rd}, {27'd0, e.rd});
                chk("bubble_count", {28'd0, bubble_count}, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        m = bubble_of('{v:1'b0, wb:1'b0, mr:1'b0, mw:1'b0, mtr:1'b0, als:1'b0,
                        pc:32'd0, a:32'd0, b:32'd0, imm:32'd0, rs1:5'd0, rs2:5'd0,
                        rd:5'd0, op:4'd0, cnt:0});
        s = idle(); s.rst = 1'b1;
        drive(s); drive(s);
        // Reset then idle
        drive(idle()); drive(idle());
        // Normal flow
        drive(instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0));
        drive(idle());
        // Load-use: lw x5 then add using x5 via rs2, held until it enters EX
        drive(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1));
        s = instr(5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
        drive(s); drive(s); drive(idle());
        // Load with Rd=0 vs Rs1=0: no stall
        drive(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1));
        drive(instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0));
        // uses_rs2=0 with matching Rs2: no stall
        drive(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1));
        drive(instr(5'd2, 1'b1, 5'd9, 1'b0, 5'd4, 1'b1, 1'b0));
        // flush together with a load-use hazard
        drive(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1));
        s = instr(5'd5, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0); s.fl = 1'b1;
        drive(s);
        // mem_stall for 3 cycles with a pending hazard, then release
        drive(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1));
        s = instr(5'd5, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0); s.ms = 1'b1;
        drive(s); drive(s); drive(s);
        s.ms = 1'b0;
        drive(s); drive(s);
        // flush during mem_stall
        drive(instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0));
        s = idle(); s.fl = 1'b1; s.ms = 1'b1;
        drive(s);
        // Saturation: a self-dependent load repeated to force more than 2^CNTW+2 bubbles
        s = instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        for (int i = 0; i < 44; i++) drive(s);
        // Randomized traffic with narrow register indices to raise hazard density
        for (int i = 0; i < 3000; i++) begin
            s = instr(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                      1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                      1'($urandom_range(0, 2) != 0));
            s.v   = ($urandom_range(0, 7) != 0);
            s.mw  = 1'($urandom);
            s.als = 1'($urandom);
            s.fl  = ($urandom_range(0, 9) == 0);
            s.ms  = ($urandom_range(0, 6) == 0);
            s.rst = ($urandom_range(0, 199) == 0);
            drive(s);
        end
        drive(idle());
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (hazards_seen < 20) begin
            errors++;
            $display("FAIL hazard_coverage: got %0d expected at least 20", hazards_seen);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
